// File: rtl/lc3_pkg.sv
// Shared encodings and defaults for the LC-3 memory-access stage.
package lc3_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;

  typedef enum logic [1:0] {
    MEM_LD  = 2'b00,
    MEM_ST  = 2'b01,
    MEM_LDI = 2'b10,
    MEM_STI = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PTR  = 2'b01,
    ST_DATA = 2'b10
  } mem_state_e;

  function automatic logic op_is_store(mem_op_e op);
    return (op == MEM_ST) || (op == MEM_STI);
  endfunction

  function automatic logic op_is_indirect(mem_op_e op);
    return (op == MEM_LDI) || (op == MEM_STI);
  endfunction

endpackage

// File: rtl/lc3_mem_timeout.sv
// Counts unanswered request cycles; o_expire flags the cycle that would make the count reach TIMEOUT.
// TIMEOUT=0 disables expiry entirely.
module lc3_mem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expire on the wait cycle that completes the TIMEOUT-th unanswered cycle, so mem_req
  // is high for exactly TIMEOUT cycles before it drops.
  assign o_expire = (TIMEOUT > 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access stage: MAR/MDR, one or two req/ready transfers per LD/ST/LDI/STI,
// load result on mdr_out, registered done/err pulse.
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = LC3_ADDR_W,
  parameter int DATA_W  = LC3_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] ea_in,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mem_state_e        r_state, w_next;
  mem_op_e           r_op;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_mdr_out;
  logic              r_gap;
  logic              r_done;
  logic              r_err;

  logic w_req, w_xfer, w_expire;
  logic w_accept, w_ptr_done, w_cmpl, w_abort;

  // r_gap holds the request low for the single cycle after the pointer read.
  assign w_req  = (r_state == ST_PTR) || ((r_state == ST_DATA) && !r_gap);
  assign w_xfer = w_req && mem_ready;

  lc3_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_clr    (!w_req),
    .i_en     (w_req && !mem_ready),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ptr_done = 1'b0;
    w_cmpl     = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = op_is_indirect(mem_op_e'(op)) ? ST_PTR : ST_DATA;
        end
      end
      ST_PTR: begin
        if (w_expire) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_xfer) begin
          w_ptr_done = 1'b1;
          w_next     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_abort = 1'b1;
          w_next  = ST_IDLE;
        end else if (w_xfer) begin
          w_cmpl = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= MEM_LD;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_mdr_out <= '0;
      r_gap     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_cmpl || w_abort;
      r_err  <= w_abort;
      r_gap  <= w_ptr_done;
      if (w_accept) begin
        r_mar <= ea_in;
        r_mdr <= st_data;
        r_op  <= mem_op_e'(op);
      end
      if (w_ptr_done) r_mar <= ADDR_W'(mem_rdata);
      if (w_cmpl && !op_is_store(r_op)) r_mdr_out <= mem_rdata;
    end
  end

  assign mem_req   = w_req;
  assign mem_we    = (r_state == ST_DATA) && op_is_store(r_op);
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign mdr_out   = r_mdr_out;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/lc3_mem_access.md
Name: lc3_mem_access

Overview:
- Memory-access stage directly downstream of the LC-3 effective-address adder. It consumes the 16-bit effective address and performs the LD/LDR, ST/STR, LDI and STI memory transactions.
- Holds the MAR and MDR registers.
- Sequences one or two req/ready handshakes with a wait-stated memory, then returns load data to the register-file writeback path.

Parameters:
- ADDR_W, 16, address width (MAR, mem_addr, ea_in)
- DATA_W, 16, data width (MDR, mem_wdata, mem_rdata)
- TIMEOUT, 255, max cycles mem_req may stay unanswered before abort; 0 disables the timeout

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a transaction; sampled only in IDLE
- op  in  2  00 LD/LDR, 01 ST/STR, 10 LDI, 11 STI
- ea_in  in  ADDR_W  effective address from the address adder
- st_data  in  DATA_W  store data (SR value)
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  current MAR
- mem_wdata  out  DATA_W  current MDR
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1
- mem_ready  in  1  memory completes the transfer this cycle
- mdr_out  out  DATA_W  load result; holds its value until the next load completes
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  timeout abort flag; valid with done

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While reset_n=0: state=IDLE; mem_req, mem_we, busy, done and err are 0; MAR, MDR and mdr_out are 0.
- Handshake rule: a transfer completes on any rising edge where mem_req=1 and mem_ready=1. mem_ready is ignored while mem_req=0.
- Stability rule: mem_addr, mem_we and mem_wdata stay constant from the cycle mem_req rises until the transfer completes.
- States: IDLE, PTR, DATA.
- IDLE:
  - On start=1, latch MAR<=ea_in, MDR<=st_data and op.
  - If op is LDI or STI, next state is PTR; otherwise next state is DATA.
  - start while busy=1 is ignored and not queued.
- PTR:
  - mem_req=1, mem_we=0, address = MAR.
  - On completion: MAR<=mem_rdata, next state DATA.
  - mem_req drops for exactly one cycle between PTR and DATA (the bus sees a new request).
- DATA:
  - mem_req=1, mem_we=1 for ST/STI, 0 for LD/LDI.
  - On completion: a load sets mdr_out<=mem_rdata; a store writes MDR to memory.
  - Next state is IDLE.
- done (registered): 1 in the first IDLE cycle after a completion or an abort, for one cycle only. A start presented in that same cycle is accepted, so back-to-back transactions run with no bubble beyond the done cycle.
- Latency with zero-wait memory (mem_ready=1 throughout):
  - LD/ST: start in cycle 0; req in cycle 1; done in cycle 2.
  - LDI/STI: done in cycle 4 (PTR cycle 1, gap cycle 2, DATA cycle 3).
  - Each memory wait cycle adds one cycle.
- Timeout:
  - A counter clears when each request begins and increments on each cycle mem_req=1 && mem_ready=0.
  - If TIMEOUT>0 and the count reaches TIMEOUT: drop mem_req, go to IDLE, pulse done=1 with err=1.
  - mdr_out and memory are unchanged by an aborted access.
  - err is 0 on every normal done.
- Reset mid-transaction: reset aborts immediately with no done pulse; mem_req falls asynchronously.
- Address wrap: the pointer read value is used verbatim as the address (x0000–xFFFF); there is no wrap logic.

Decomposition:
- Shared package lc3_pkg holds:
  - op encodings MEM_LD, MEM_ST, MEM_LDI, MEM_STI
  - state encodings for IDLE, PTR, DATA
  - ADDR_W/DATA_W defaults
- One natural sub-module, lc3_mem_timeout: a counter with clear, enable and expire outputs, parameterised by TIMEOUT. It is instantiated once.

Test Plan:
- LD, ea_in=x3000, memory holds x3000=xBEEF, zero wait -> mem_req high cycle 1 with addr x3000, we=0; done cycle 2; mdr_out=xBEEF; err=0.
- ST, ea_in=x4001, st_data=x1234, 3 wait cycles -> addr, we=1 and wdata=x1234 stable for 4 request cycles; x4001=x1234 afterwards; done 1 cycle after completion.
- LDI, ea_in=x3005, memory x3005=x5000 and x5000=xA5A5 -> two requests (x3005 then x5000) with a 1-cycle req gap; mdr_out=xA5A5 at done (cycle 4).
- Timeout, TIMEOUT=4, mem_ready held 0 on an LD -> mem_req drops after 4 cycles; done=1 and err=1 together; mdr_out keeps its old value; next LD succeeds normally.
- Protocol edges:
  - start pulsed while busy -> ignored.
  - start in the done cycle -> accepted, new req on the next cycle.
  - mem_ready=1 while idle -> no effect.
- Reset mid-STI (in the DATA state) -> mem_req=0 immediately; all outputs return to reset values; no done pulse; no memory write occurs.
